// File: rtl/sort_pkg.sv
// Shared types and the element compare used by the selection-sort controller.
// Pure declarations; no state, no timing.
package sort_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        RD_I   = 4'd1,
        LD_I   = 4'd2,
        RD_J   = 4'd3,
        CMP_J  = 4'd4,
        SW_A   = 4'd5,
        SW_B   = 4'd6,
        NEXT_I = 4'd7,
        DONE   = 4'd8
    } sort_state_e;

    // Signed compare flips the sign bit so one unsigned compare serves both modes.
    function automatic logic elem_lt(input logic [63:0] a, input logic [63:0] b,
                                     input int unsigned w, input logic signed_cmp);
        logic [63:0] flip;
        flip = signed_cmp ? (64'd1 << (w - 1)) : 64'd0;
        return (a ^ flip) < (b ^ flip);
    endfunction

endpackage

// File: rtl/sel_sort_ctrl_if.sv
// Command and element-RAM signals of the selection-sort controller.
// slave = controller side, master = host/RAM side.
interface sel_sort_ctrl_if #(
    parameter int SIZE_ADDR = 8,
    parameter int DATA_W    = 16
);
    logic                 i_start;
    logic [SIZE_ADDR:0]   i_num_elems;
    logic                 o_busy;
    logic                 o_done;
    logic [SIZE_ADDR:0]   o_swap_cnt;
    logic [SIZE_ADDR-1:0] o_mem_addr;
    logic                 o_mem_rd_en;
    logic                 o_mem_wr_en;
    logic [DATA_W-1:0]    o_mem_wdata;
    logic [DATA_W-1:0]    i_mem_rdata;

    modport slave (
        input  i_start, i_num_elems, i_mem_rdata,
        output o_busy, o_done, o_swap_cnt, o_mem_addr, o_mem_rd_en, o_mem_wr_en, o_mem_wdata
    );

    modport master (
        output i_start, i_num_elems, i_mem_rdata,
        input  o_busy, o_done, o_swap_cnt, o_mem_addr, o_mem_rd_en, o_mem_wr_en, o_mem_wdata
    );
endinterface

// File: rtl/sort_min_tracker.sv
// Running-minimum register pair (value + index) for one inner scan.
// Updates one cycle after load/upd; lt is combinational against the held minimum.
module sort_min_tracker
    import sort_pkg::*;
#(
    parameter int IW         = 9,
    parameter int DATA_W     = 16,
    parameter int SIGNED_CMP = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              load,
    input  logic              upd,
    input  logic [DATA_W-1:0] cand_val,
    input  logic [IW-1:0]     cand_idx,
    output logic [DATA_W-1:0] min_val,
    output logic [IW-1:0]     min_idx,
    output logic              lt
);

    // Strict less-than: equal candidates never displace the current minimum.
    assign lt = elem_lt(64'(cand_val), 64'(min_val), DATA_W, SIGNED_CMP != 0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            min_val <= '0;
            min_idx <= '0;
        end else if (load || (upd && lt)) begin
            min_val <= cand_val;
            min_idx <= cand_idx;
        end
    end

endmodule

// File: rtl/sel_sort_ctrl.sv
// In-place ascending selection sort over a 1-cycle-latency single-port RAM.
// Per outer step: 3 + 2*(N-1-i) cycles, +2 on swap; start is ignored while busy.
module sel_sort_ctrl
    import sort_pkg::*;
#(
    parameter int SIZE_ADDR  = 8,
    parameter int DATA_W     = 16,
    parameter int SIGNED_CMP = 0
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    sel_sort_ctrl_if.slave bus
);

    localparam int IW = SIZE_ADDR + 1;
    localparam logic [IW-1:0] MAX_N = {1'b1, {SIZE_ADDR{1'b0}}};
    localparam logic [IW-1:0] ONE   = IW'(1);

    sort_state_e          state, state_nxt;
    logic [IW-1:0]        n, n_nxt;
    logic [IW-1:0]        i, i_nxt;
    logic [IW-1:0]        j, j_nxt;
    logic [DATA_W-1:0]    ival, ival_nxt;
    logic [IW-1:0]        swap_cnt, swap_nxt;
    logic                 done_q, done_nxt;
    logic                 rd_en_q, rd_en_nxt;
    logic                 wr_en_q, wr_en_nxt;
    logic [SIZE_ADDR-1:0] addr_q, addr_nxt;
    logic [DATA_W-1:0]    wdata_q, wdata_nxt;

    logic                 ld_min, upd_min, lt;
    logic [DATA_W-1:0]    min_val, min_val_upd;
    logic [IW-1:0]        min_idx, min_idx_upd, cand_idx, n_clamp;

    assign cand_idx    = ld_min ? i : j;
    assign min_val_upd = lt ? bus.i_mem_rdata : min_val;
    assign min_idx_upd = lt ? j : min_idx;
    assign n_clamp     = (bus.i_num_elems > MAX_N) ? MAX_N : bus.i_num_elems;

    sort_min_tracker #(
        .IW         (IW),
        .DATA_W     (DATA_W),
        .SIGNED_CMP (SIGNED_CMP)
    ) u_min (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .load     (ld_min),
        .upd      (upd_min),
        .cand_val (bus.i_mem_rdata),
        .cand_idx (cand_idx),
        .min_val  (min_val),
        .min_idx  (min_idx),
        .lt       (lt)
    );

    always_comb begin
        state_nxt = state;
        n_nxt     = n;
        i_nxt     = i;
        j_nxt     = j;
        ival_nxt  = ival;
        swap_nxt  = swap_cnt;
        ld_min    = 1'b0;
        upd_min   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    n_nxt     = n_clamp;
                    swap_nxt  = '0;
                    i_nxt     = '0;
                    state_nxt = (n_clamp <= ONE) ? DONE : RD_I;
                end
            end
            RD_I:  state_nxt = LD_I;
            LD_I: begin
                ival_nxt  = bus.i_mem_rdata;
                ld_min    = 1'b1;
                j_nxt     = i + ONE;
                state_nxt = RD_J;
            end
            RD_J:  state_nxt = CMP_J;
            CMP_J: begin
                upd_min = 1'b1;
                j_nxt   = j + ONE;
                if (j_nxt == n)
                    state_nxt = (min_idx_upd != i) ? SW_A : NEXT_I;
                else
                    state_nxt = RD_J;
            end
            SW_A:  state_nxt = SW_B;
            SW_B: begin
                swap_nxt  = swap_cnt + ONE;
                state_nxt = NEXT_I;
            end
            NEXT_I: begin
                i_nxt     = i + ONE;
                state_nxt = (i_nxt == n - ONE) ? DONE : RD_I;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        // Strobes are decoded from the next state so they are registered and
        // line up with the cycle spent in that state.
        rd_en_nxt = (state_nxt == RD_I) || (state_nxt == RD_J);
        wr_en_nxt = (state_nxt == SW_A) || (state_nxt == SW_B);
        done_nxt  = (state_nxt == DONE);
        addr_nxt  = '0;
        wdata_nxt = '0;
        case (state_nxt)
            RD_I: addr_nxt = i_nxt[SIZE_ADDR-1:0];
            RD_J: addr_nxt = j_nxt[SIZE_ADDR-1:0];
            SW_A: begin
                addr_nxt  = i[SIZE_ADDR-1:0];
                wdata_nxt = min_val_upd;
            end
            SW_B: begin
                addr_nxt  = min_idx[SIZE_ADDR-1:0];
                wdata_nxt = ival;
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            n        <= '0;
            i        <= '0;
            j        <= '0;
            ival     <= '0;
            swap_cnt <= '0;
            done_q   <= 1'b0;
            rd_en_q  <= 1'b0;
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state    <= state_nxt;
            n        <= n_nxt;
            i        <= i_nxt;
            j        <= j_nxt;
            ival     <= ival_nxt;
            swap_cnt <= swap_nxt;
            done_q   <= done_nxt;
            rd_en_q  <= rd_en_nxt;
            wr_en_q  <= wr_en_nxt;
            addr_q   <= addr_nxt;
            wdata_q  <= wdata_nxt;
        end
    end

    assign bus.o_busy      = (state != IDLE);
    assign bus.o_done      = done_q;
    assign bus.o_swap_cnt  = swap_cnt;
    assign bus.o_mem_addr  = addr_q;
    assign bus.o_mem_rd_en = rd_en_q;
    assign bus.o_mem_wr_en = wr_en_q;
    assign bus.o_mem_wdata = wdata_q;

endmodule

// File: tb/tb_sel_sort_ctrl.sv
// Directed bench: unsigned and signed controllers, each with its own 8-entry RAM model.
module tb_sel_sort_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sel_sort_ctrl_if #(.SIZE_ADDR(3), .DATA_W(8)) b0 ();
    sel_sort_ctrl_if #(.SIZE_ADDR(3), .DATA_W(8)) b1 ();

    sel_sort_ctrl #(.SIZE_ADDR(3), .DATA_W(8), .SIGNED_CMP(0)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b0));
    sel_sort_ctrl #(.SIZE_ADDR(3), .DATA_W(8), .SIGNED_CMP(1)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .bus(b1));

    logic [7:0] mem0 [8];
    logic [7:0] mem1 [8];
    logic [7:0] pre  [8];
    logic       ld0 = 1'b0;
    logic       ld1 = 1'b0;

    int total = 0;
    int bad   = 0;
    int dn0 = 0, wr0 = 0, acc0 = 0, dn1 = 0, both = 0;

    always @(posedge clk) begin
        if (ld0) for (int k = 0; k < 8; k++) mem0[k] <= pre[k];
        else if (b0.o_mem_wr_en) mem0[b0.o_mem_addr] <= b0.o_mem_wdata;
        if (b0.o_mem_rd_en) b0.i_mem_rdata <= mem0[b0.o_mem_addr];
        if (ld1) for (int k = 0; k < 8; k++) mem1[k] <= pre[k];
        else if (b1.o_mem_wr_en) mem1[b1.o_mem_addr] <= b1.o_mem_wdata;
        if (b1.o_mem_rd_en) b1.i_mem_rdata <= mem1[b1.o_mem_addr];
    end

    always @(posedge clk) begin
        if (b0.o_done) dn0 <= dn0 + 1;
        if (b1.o_done) dn1 <= dn1 + 1;
        if (b0.o_mem_wr_en) wr0 <= wr0 + 1;
        if (b0.o_mem_wr_en || b0.o_mem_rd_en) acc0 <= acc0 + 1;
        if ((b0.o_mem_wr_en && b0.o_mem_rd_en) || (b1.o_mem_wr_en && b1.o_mem_rd_en))
            both <= both + 1;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pk(input bit w);
        logic [63:0] v;
        for (int k = 0; k < 8; k++) v[8*k +: 8] = w ? mem1[k] : mem0[k];
        return v;
    endfunction

    task automatic load(input bit w, input logic [63:0] v);
        for (int k = 0; k < 8; k++) pre[k] = v[8*k +: 8];
        ld0 = !w;
        ld1 = w;
        @(negedge clk);
        ld0 = 1'b0;
        ld1 = 1'b0;
    endtask

    task automatic drv(input bit w, input logic s, input logic [3:0] n);
        if (w) begin b1.i_start = s; b1.i_num_elems = n; end
        else   begin b0.i_start = s; b0.i_num_elems = n; end
    endtask

    // cyc = index of the cycle (1 = first after the sampling edge) in which o_done is seen.
    task automatic run(input bit w, input logic [3:0] n, input bit poke, output int cyc);
        @(negedge clk);
        drv(w, 1'b1, n);
        @(negedge clk);
        drv(w, 1'b0, n);
        cyc = 1;
        while (!(w ? b1.o_done : b0.o_done) && cyc < 400) begin
            if (poke && cyc == 4) drv(w, 1'b1, 4'd2);
            else drv(w, 1'b0, n);
            @(negedge clk);
            cyc++;
        end
        drv(w, 1'b0, n);
    endtask

    int cyc, s_dn, s_wr, s_acc;

    initial begin
        drv(0, 1'b0, 4'd0);
        drv(1, 1'b0, 4'd0);
        repeat (2) @(negedge clk);
        chk("rst_busy",  64'(b0.o_busy), 64'd0);
        chk("rst_done",  64'(b0.o_done), 64'd0);
        chk("rst_rd",    64'(b0.o_mem_rd_en), 64'd0);
        chk("rst_wr",    64'(b0.o_mem_wr_en), 64'd0);
        chk("rst_addr",  64'(b0.o_mem_addr), 64'd0);
        chk("rst_wdata", 64'(b0.o_mem_wdata), 64'd0);
        chk("rst_swap",  64'(b0.o_swap_cnt), 64'd0);
        rst_n = 1'b1;

        // already sorted: no writes at all
        load(0, 64'hAAAAAAAA_04030201);
        s_dn = dn0; s_wr = wr0;
        run(0, 4'd4, 0, cyc);
        chk("sorted_cyc",  64'(cyc), 64'd22);
        chk("sorted_swap", 64'(b0.o_swap_cnt), 64'd0);
        @(negedge clk);
        chk("sorted_wr",   64'(wr0 - s_wr), 64'd0);
        chk("sorted_mem",  pk(0), 64'hAAAAAAAA_04030201);
        chk("sorted_busy", 64'(b0.o_busy), 64'd0);
        chk("sorted_dn",   64'(dn0 - s_dn), 64'd1);

        // reversed
        load(0, 64'hAAAAAAAA_01020304);
        s_dn = dn0;
        run(0, 4'd4, 0, cyc);
        chk("rev_cyc",  64'(cyc), 64'd26);
        chk("rev_swap", 64'(b0.o_swap_cnt), 64'd2);
        @(negedge clk);
        chk("rev_pulse", 64'(b0.o_done), 64'd0);
        repeat (2) @(negedge clk);
        chk("rev_mem", pk(0), 64'hAAAAAAAA_04030201);
        chk("rev_dn",  64'(dn0 - s_dn), 64'd1);

        // N = 1 and N = 0: straight to DONE, no RAM traffic
        for (int nn = 1; nn >= 0; nn--) begin
            s_acc = acc0;
            run(0, 4'(nn), 0, cyc);
            chk($sformatf("n%0d_cyc", nn), 64'(cyc), 64'd1);
            @(negedge clk);
            chk($sformatf("n%0d_busy", nn), 64'(b0.o_busy), 64'd0);
            chk($sformatf("n%0d_acc", nn), 64'(acc0 - s_acc), 64'd0);
        end

        // unsigned vs signed ordering of {05,FF,80,00}
        load(0, 64'hAAAAAAAA_0080FF05);
        run(0, 4'd4, 0, cyc);
        @(negedge clk);
        chk("uns_mem", pk(0), 64'hAAAAAAAA_FF800500);
        load(1, 64'hAAAAAAAA_0080FF05);
        s_dn = dn1;
        run(1, 4'd4, 0, cyc);
        @(negedge clk);
        chk("sgn_mem", pk(1), 64'hAAAAAAAA_0500FF80);
        chk("sgn_dn",  64'(dn1 - s_dn), 64'd1);

        // duplicates, with a stray start (N=2) while busy
        load(0, 64'hAAAAAAAA_01020102);
        run(0, 4'd4, 1, cyc);
        chk("dup_cyc",  64'(cyc), 64'd26);
        chk("dup_swap", 64'(b0.o_swap_cnt), 64'd2);
        @(negedge clk);
        chk("dup_mem",  pk(0), 64'hAAAAAAAA_02020101);
        chk("dup_busy", 64'(b0.o_busy), 64'd0);

        // N = 15 clamps to 8; j reaches 8 without wrapping
        load(0, 64'h01020304_05060708);
        run(0, 4'd15, 0, cyc);
        chk("clamp_cyc",  64'(cyc), 64'd86);
        chk("clamp_swap", 64'(b0.o_swap_cnt), 64'd4);
        @(negedge clk);
        chk("clamp_mem",  pk(0), 64'h08070605_04030201);

        // reset during CMP_J of i=1
        load(0, 64'hAAAAAAAA_01020304);
        @(negedge clk);
        drv(0, 1'b1, 4'd4);
        @(negedge clk);
        drv(0, 1'b0, 4'd4);
        repeat (13) @(negedge clk);
        chk("mid_rd",   64'(b0.o_mem_rd_en), 64'd1);
        chk("mid_addr", 64'(b0.o_mem_addr), 64'd2);
        @(negedge clk);
        s_dn = dn0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 64'(b0.o_busy), 64'd0);
        chk("abort_rd",   64'(b0.o_mem_rd_en), 64'd0);
        chk("abort_wr",   64'(b0.o_mem_wr_en), 64'd0);
        chk("abort_swap", 64'(b0.o_swap_cnt), 64'd0);
        chk("abort_done", 64'(b0.o_done), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("abort_mem", pk(0), 64'hAAAAAAAA_04020301);
        chk("abort_dn",  64'(dn0 - s_dn), 64'd0);
        run(0, 4'd4, 0, cyc);
        chk("resort_cyc",  64'(cyc), 64'd24);
        chk("resort_swap", 64'(b0.o_swap_cnt), 64'd1);
        @(negedge clk);
        chk("resort_mem",  pk(0), 64'hAAAAAAAA_04030201);

        chk("rd_wr_overlap", 64'(both), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
